// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module : cpu_types_pkg
// Brief  : Shared RAM-handshake types, word type and arbiter FSM encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef logic [DATA_W-1:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DGRANT = 2'd1,
      IGRANT = 2'd2
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
// ============================================================================
// Module : cache_mem_arbiter
// Brief  : Shares one RAM port between icache and dcache, dcache-first with a
//          bounded dcache streak. Optional perf counters under ARB_PERF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cache_mem_arbiter #(
   parameter int ADDR_W       = cpu_types_pkg::ADDR_W,
   parameter int DATA_W       = cpu_types_pkg::DATA_W,
   parameter int MAX_D_STREAK = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [DATA_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              dwait,
   output logic [DATA_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic [1:0]        ramstate
`ifdef ARB_PERF_EN
   ,
   output logic [31:0]       perf_icount,
   output logic [31:0]       perf_dcount,
   output logic [31:0]       perf_stall
`endif
);

   import cpu_types_pkg::*;

   localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
   localparam logic [STREAK_W-1:0] c_STREAK_MAX = STREAK_W'(MAX_D_STREAK);

   arb_state_t          r_state;
   arb_state_t          w_state_next;
   logic [STREAK_W-1:0] r_dstreak;
   logic [STREAK_W-1:0] w_dstreak_next;
   logic                w_dreq;
   logic                w_access;

   assign w_dreq   = dREN | dWEN;
   assign w_access = (ramstate == ACCESS);

   always_comb begin
      w_state_next   = r_state;
      w_dstreak_next = r_dstreak;
      ramREN         = 1'b0;
      ramWEN         = 1'b0;
      ramaddr        = '0;
      ramstore       = '0;
      iwait          = 1'b1;
      dwait          = 1'b1;
      iload          = '0;
      dload          = '0;

      case (r_state)
         IDLE: begin
            if (w_dreq && (!iREN || (r_dstreak < c_STREAK_MAX)))
               w_state_next = DGRANT;
            else if (iREN)
               w_state_next = IGRANT;
         end

         DGRANT: begin
            ramaddr  = daddr;
            ramstore = dstore;
            if (!w_dreq) begin
               w_state_next = IDLE;
            end else begin
               ramWEN = dWEN;
               ramREN = dREN & ~dWEN;
               if (w_access) begin
                  dwait        = 1'b0;
                  dload        = ramload;
                  w_state_next = IDLE;
                  // Streak only grows while the icache is actually kept waiting
                  if (!iREN)
                     w_dstreak_next = '0;
                  else if (r_dstreak != c_STREAK_MAX)
                     w_dstreak_next = r_dstreak + STREAK_W'(1);
               end
            end
         end

         IGRANT: begin
            ramaddr = iaddr;
            if (!iREN) begin
               w_state_next = IDLE;
            end else begin
               ramREN = 1'b1;
               if (w_access) begin
                  iwait          = 1'b0;
                  iload          = ramload;
                  w_dstreak_next = '0;
                  w_state_next   = IDLE;
               end
            end
         end

         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= IDLE;
         r_dstreak <= '0;
      end else begin
         r_state   <= w_state_next;
         r_dstreak <= w_dstreak_next;
      end
   end

`ifdef ARB_PERF_EN
   logic [31:0] r_perf_icount;
   logic [31:0] r_perf_dcount;
   logic [31:0] r_perf_stall;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_perf_icount <= '0;
         r_perf_dcount <= '0;
         r_perf_stall  <= '0;
      end else begin
         if (!iwait)
            r_perf_icount <= r_perf_icount + 32'd1;
         if (!dwait)
            r_perf_dcount <= r_perf_dcount + 32'd1;
         if ((iREN | w_dreq) && iwait && dwait)
            r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign perf_icount = r_perf_icount;
   assign perf_dcount = r_perf_dcount;
   assign perf_stall  = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
// ============================================================================
// Module : tb_cache_mem_arbiter
// Brief  : Directed self-checking bench for cache_mem_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cache_mem_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [1:0]  ramstate;
   logic        iwait, dwait, ramREN, ramWEN;
   logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef ARB_PERF_EN
   logic [31:0] perf_icount, perf_dcount, perf_stall;
`endif

   int n_total = 0;
   int n_bad   = 0;

   always #5 CLK = ~CLK;

   cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
`ifdef ARB_PERF_EN
      ,
      .perf_icount(perf_icount), .perf_dcount(perf_dcount),
      .perf_stall(perf_stall)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are then changed and outputs sampled mid-cycle
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
      iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
      step(); step();
      settle();
      chk("rst_iwait", {31'd0, iwait}, 32'd1);
      chk("rst_dwait", {31'd0, dwait}, 32'd1);
      chk("rst_en", {30'd0, ramREN, ramWEN}, 32'd0);
      chk("rst_addr", ramaddr, 32'd0);
      chk("rst_loads", iload | dload, 32'd0);

      // icache single read, ACCESS on first grant cycle
      RST = 0; iREN = 1; iaddr = 32'h100; settle();
      chk("i1_idle_ren", {31'd0, ramREN}, 32'd0);
      chk("i1_idle_iwait", {31'd0, iwait}, 32'd1);
      step(); ramstate = 2'd2; ramload = 32'hDEADBEEF; settle();
      chk("i1_ren", {31'd0, ramREN}, 32'd1);
      chk("i1_addr", ramaddr, 32'h100);
      chk("i1_iwait", {31'd0, iwait}, 32'd0);
      chk("i1_iload", iload, 32'hDEADBEEF);
      step(); iREN = 0; ramstate = 2'd0; settle();
      chk("i1_after_iwait", {31'd0, iwait}, 32'd1);
      chk("i1_after_iload", iload, 32'd0);

      // dcache write, 3 BUSY cycles then ACCESS
      dWEN = 1; daddr = 32'h200; dstore = 32'h12345678; settle();
      chk("d2_idle_wen", {31'd0, ramWEN}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         ramstate = (k == 3) ? 2'd2 : 2'd1;
         settle();
         chk("d2_wen", {31'd0, ramWEN}, 32'd1);
         chk("d2_store", ramstore, 32'h12345678);
         chk("d2_addr", ramaddr, 32'h200);
         chk("d2_dwait", {31'd0, dwait}, (k == 3) ? 32'd0 : 32'd1);
         chk("d2_iwait", {31'd0, iwait}, 32'd1);
      end
      step(); dWEN = 0; ramstate = 2'd0; settle();
      chk("d2_after_dwait", {31'd0, dwait}, 32'd1);

      // Contention with immediate retire: D,D,D,D,I,D
      iREN = 1; dREN = 1; iaddr = 32'h400; daddr = 32'h300;
      ramstate = 2'd2; ramload = 32'h0000_5555; settle();
      for (int k = 0; k < 12; k++) begin
         logic exp_d, exp_i;
         exp_d = (k % 2 == 1) && (k != 9);
         exp_i = (k == 9);
         chk($sformatf("str_dwait_%0d", k), {31'd0, dwait}, {31'd0, ~exp_d});
         chk($sformatf("str_iwait_%0d", k), {31'd0, iwait}, {31'd0, ~exp_i});
         if (exp_d) chk($sformatf("str_dload_%0d", k), dload, 32'h0000_5555);
         step();
      end
      iREN = 0; dREN = 0; ramstate = 2'd0; step(); settle();

      // icache read with two ERROR cycles
      iREN = 1; iaddr = 32'h500; ramstate = 2'd3; settle();
      for (int k = 0; k < 3; k++) begin
         step();
         if (k == 2) begin ramstate = 2'd2; ramload = 32'hA5A5A5A5; end
         settle();
         chk("e4_ren", {31'd0, ramREN}, 32'd1);
         chk("e4_addr", ramaddr, 32'h500);
         chk("e4_iwait", {31'd0, iwait}, (k == 2) ? 32'd0 : 32'd1);
         chk("e4_iload", iload, (k == 2) ? 32'hA5A5A5A5 : 32'd0);
      end
      step(); iREN = 0; ramstate = 2'd0; settle();
      chk("e4_after_iwait", {31'd0, iwait}, 32'd1);

      // Reset during a BUSY dcache write
      dWEN = 1; daddr = 32'h600; dstore = 32'h0BAD_F00D; settle();
      step(); ramstate = 2'd1; settle();
      chk("r5_wen", {31'd0, ramWEN}, 32'd1);
      RST = 1;
      step(); RST = 0; ramstate = 2'd2; settle();
      chk("r5_en", {30'd0, ramREN, ramWEN}, 32'd0);
      chk("r5_dwait", {31'd0, dwait}, 32'd1);
      step(); settle();
      chk("r5_regrant_dwait", {31'd0, dwait}, 32'd0);
      step(); dWEN = 0; ramstate = 2'd0; settle();

      // dREN and dWEN together: write wins
      dREN = 1; dWEN = 1; daddr = 32'h700; ramstate = 2'd1; settle();
      step(); settle();
      chk("w6_en", {30'd0, ramREN, ramWEN}, 32'd1);
      ramstate = 2'd2; settle();
      chk("w6_dwait", {31'd0, dwait}, 32'd0);
      step(); dWEN = 0; ramstate = 2'd1; settle();

      // dREN dropped mid-grant
      step(); settle();
      chk("x6_ren", {31'd0, ramREN}, 32'd1);
      step(); dREN = 0; ramstate = 2'd2; settle();
      chk("x6_drop_en", {30'd0, ramREN, ramWEN}, 32'd0);
      chk("x6_drop_dwait", {31'd0, dwait}, 32'd1);
      step(); dREN = 1; settle();
      chk("x6_idle_ren", {31'd0, ramREN}, 32'd0);
      chk("x6_idle_dwait", {31'd0, dwait}, 32'd1);
      dREN = 0; ramstate = 2'd0;
      step();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
